// File: rtl/sdk_pkg.sv
// Shared types and constants for the SDK receive deframer.
// Holds the FSM state enum, the SDK word width and the default header magic.
package sdk_pkg;
  localparam int         SDK_DW    = 16;
  localparam logic [7:0] SDK_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD
  } state_t;
endpackage

// File: rtl/sdk_rx_deframer_if.sv
// Bundle of the FWFT FIFO read side and the payload stream of the deframer.
// The deframer uses the master modport; the FIFO/sink environment uses slave.
interface sdk_rx_deframer_if;
  logic                       SDK_Empty;
  logic [sdk_pkg::SDK_DW-1:0] SDK_DI;
  logic                       SDK_RD;
  logic                       out_valid;
  logic                       out_ready;
  logic [sdk_pkg::SDK_DW-1:0] out_data;
  logic                       out_sop;
  logic                       out_eop;
  logic [7:0]                 out_tag;

  modport master (
    input  SDK_Empty, SDK_DI, out_ready,
    output SDK_RD, out_valid, out_data, out_sop, out_eop, out_tag
  );

  modport slave (
    output SDK_Empty, SDK_DI, out_ready,
    input  SDK_RD, out_valid, out_data, out_sop, out_eop, out_tag
  );
endinterface

// File: rtl/sdk_out_reg.sv
// One-entry valid/ready output register carrying payload data, sop, eop and tag.
// A load in the same cycle as an accept refills the entry, sustaining one word per clock.
module sdk_out_reg #(
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_sop,
  input  logic          i_eop,
  input  logic [7:0]    i_tag,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_sop,
  output logic          o_eop,
  output logic [7:0]    o_tag
);
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_sop;
  logic          r_eop;
  logic [7:0]    r_tag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_tag   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_sop   <= i_sop;
      r_eop   <= i_eop;
      r_tag   <= i_tag;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sop   = r_sop;
  assign o_eop   = r_eop;
  assign o_tag   = r_tag;
endmodule

// File: rtl/sdk_rx_deframer.sv
// Pops [header][length][payload x N] frames from the SDK FWFT FIFO and streams the payload.
// Malformed headers and lengths are dropped with a one-cycle error pulse.
module sdk_rx_deframer
  import sdk_pkg::*;
#(
  parameter logic [7:0] MAGIC   = SDK_MAGIC,
  parameter int         MAX_LEN = 1024,
  parameter int         CNT_W   = 16
) (
  input  logic              SDK_CLK,
  input  logic              SDK_RSTN,
  sdk_rx_deframer_if.master bus,
  output logic              busy,
  output logic              err_magic,
  output logic              err_len,
  output logic [CNT_W-1:0]  frame_cnt
);
  localparam int                REM_W     = $clog2(MAX_LEN + 1);
  localparam logic [SDK_DW-1:0] MAX_LEN_W = SDK_DW'(MAX_LEN);

  state_t             r_state;
  logic [REM_W-1:0]   r_remaining;
  logic               r_first;
  logic [7:0]         r_tag_nxt;
  logic               r_err_magic;
  logic               r_err_len;
  logic [CNT_W-1:0]   r_frame_cnt;

  logic w_can_take;
  logic w_pop;
  logic w_load;
  logic w_last;
  logic w_len_ok;
  logic w_eop_accept;

  assign w_can_take   = (r_state == PAYLOAD) ? (~bus.out_valid | bus.out_ready) : 1'b1;
  // Reset also blocks the pop so the FIFO is never drained while outputs are held at zero.
  assign w_pop        = SDK_RSTN & ~bus.SDK_Empty & w_can_take;
  assign w_load       = w_pop & (r_state == PAYLOAD);
  assign w_last       = (r_remaining == REM_W'(1));
  assign w_len_ok     = (bus.SDK_DI != '0) && (bus.SDK_DI <= MAX_LEN_W);
  assign w_eop_accept = bus.out_valid & bus.out_ready & bus.out_eop;

  always_ff @(posedge SDK_CLK or negedge SDK_RSTN) begin
    if (!SDK_RSTN) begin
      r_state     <= HUNT;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_tag_nxt   <= '0;
      r_err_magic <= 1'b0;
      r_err_len   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_err_magic <= 1'b0;
      r_err_len   <= 1'b0;
      if (w_eop_accept) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        case (r_state)
          HUNT: begin
            if (bus.SDK_DI[15:8] == MAGIC) begin
              r_tag_nxt <= bus.SDK_DI[7:0];
              r_state   <= LEN;
            end else begin
              r_err_magic <= 1'b1;
            end
          end
          LEN: begin
            if (w_len_ok) begin
              r_remaining <= bus.SDK_DI[REM_W-1:0];
              r_first     <= 1'b1;
              r_state     <= PAYLOAD;
            end else begin
              r_err_len <= 1'b1;
              r_state   <= HUNT;
            end
          end
          PAYLOAD: begin
            r_remaining <= r_remaining - REM_W'(1);
            r_first     <= 1'b0;
            if (w_last) begin
              r_state <= HUNT;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  sdk_out_reg #(
    .DW (SDK_DW)
  ) u_out_reg (
    .i_clk   (SDK_CLK),
    .i_rst_n (SDK_RSTN),
    .i_load  (w_load),
    .i_data  (bus.SDK_DI),
    .i_sop   (r_first),
    .i_eop   (w_last),
    .i_tag   (r_tag_nxt),
    .i_ready (bus.out_ready),
    .o_valid (bus.out_valid),
    .o_data  (bus.out_data),
    .o_sop   (bus.out_sop),
    .o_eop   (bus.out_eop),
    .o_tag   (bus.out_tag)
  );

  assign bus.SDK_RD = w_pop;
  assign busy       = (r_state != HUNT) | bus.out_valid;
  assign err_magic  = r_err_magic;
  assign err_len    = r_err_len;
  assign frame_cnt  = r_frame_cnt;
endmodule
